button_sequencer: RTL and testbench

Time-set controller between the three debounced front-panel buttons (MODE, UP, DOWN) and the clock's time registers. It turns stable button levels into a set-mode state machine and single-cycle edit strobes. Held UP/DOWN auto-repeat, and an idle edit session falls back to run mode. All timing is counted in `tick` strobes, so the block is independent of the system clock frequency.

---
 rtl/numitron_pkg.sv | 25 ++
 rtl/key_repeat.sv | 60 ++++++
 rtl/button_sequencer.sv | 99 +++++++++
 tb/tb_button_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/numitron_pkg.sv
// Shared types and default timing constants for the front-panel time-set logic.
package numitron_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int DEF_HOLD_TICKS    = 500;
  localparam int DEF_REPEAT_TICKS  = 100;
  localparam int DEF_TIMEOUT_TICKS = 30000;
  localparam int DEF_CNT_W         = 16;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_HR;
      SET_HR:  return SET_MIN;
      SET_MIN: return SET_SEC;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Press-edge detection plus hold/auto-repeat timing for one edit button.
// press is the raw edge; rep fires on the tick that completes the hold or repeat interval.
module key_repeat #(
  parameter int CNT_W        = 16,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  input  logic enable,
  input  logic clear,
  output logic press,
  output logic rep
);

  logic             lvl_q;
  logic             armed;
  logic             in_repeat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] target;
  logic             active;

  assign press   = level & ~lvl_q;
  assign cnt_nxt = cnt + CNT_W'(1);
  assign target  = in_repeat ? CNT_W'(REPEAT_TICKS) : CNT_W'(HOLD_TICKS);
  assign active  = armed & level & enable & ~clear;
  assign rep     = active & tick & ~press & (cnt_nxt == target);

  // lvl_q resets to 1 so a button held through reset never looks like a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q     <= 1'b1;
      armed     <= 1'b0;
      in_repeat <= 1'b0;
      cnt       <= '0;
    end else begin
      lvl_q <= level;
      if (clear || !enable || !level) begin
        armed     <= 1'b0;
        in_repeat <= 1'b0;
        cnt       <= '0;
      end else if (press) begin
        armed     <= 1'b1;
        in_repeat <= 1'b0;
        cnt       <= '0;
      end else if (active && tick) begin
        if (rep) begin
          in_repeat <= 1'b1;
          cnt       <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/button_sequencer.sv
// Time-set controller: MODE steps through the set modes, UP/DOWN produce edit strobes.
//   state   | meaning
//   RUN     | clock running, UP/DOWN ignored
//   SET_HR  | UP/DOWN adjust hours, with auto-repeat
//   SET_MIN | UP/DOWN adjust minutes, with auto-repeat
//   SET_SEC | UP/DOWN zero seconds, single shot
module button_sequencer
  import numitron_pkg::*;
#(
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       inc,
  output logic       dec,
  output logic       sec_clr,
  output logic       commit
);

  mode_t            state;
  logic             mode_lvl_q;
  logic             wait_q;
  logic [CNT_W-1:0] tcnt;

  logic mode_edge, both, clear, edit, in_set;
  logic up_press, up_rep, dn_press, dn_rep;
  logic inc_nxt, dec_nxt, sec_nxt, activity, timeout_fire;

  assign mode      = state;
  assign mode_edge = btn_mode & ~mode_lvl_q;
  assign both      = btn_up & btn_down;
  assign edit      = (state == SET_HR) || (state == SET_MIN);
  assign in_set    = (state != RUN);
  // wait_q keeps UP/DOWN disarmed after a mode change or a double press until both are up
  assign clear     = mode_edge | both | wait_q;

  key_repeat #(
    .CNT_W(CNT_W), .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) u_key_up (
    .clk(clk), .rst(rst), .tick(tick), .level(btn_up), .enable(edit), .clear(clear),
    .press(up_press), .rep(up_rep)
  );

  key_repeat #(
    .CNT_W(CNT_W), .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) u_key_down (
    .clk(clk), .rst(rst), .tick(tick), .level(btn_down), .enable(edit), .clear(clear),
    .press(dn_press), .rep(dn_rep)
  );

  assign inc_nxt      = up_rep | (edit & ~clear & up_press);
  assign dec_nxt      = dn_rep | (edit & ~clear & dn_press);
  assign sec_nxt      = (state == SET_SEC) & ~clear & (up_press | dn_press);
  assign activity     = mode_edge | up_press | dn_press | up_rep | dn_rep;
  assign timeout_fire = in_set & tick & ~activity & (tcnt >= CNT_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      mode_lvl_q <= 1'b1;
      wait_q     <= 1'b1;
      tcnt       <= '0;
      inc        <= 1'b0;
      dec        <= 1'b0;
      sec_clr    <= 1'b0;
      commit     <= 1'b0;
    end else begin
      mode_lvl_q <= btn_mode;
      wait_q     <= (timeout_fire | mode_edge | both | wait_q) & (btn_up | btn_down);
      inc        <= inc_nxt;
      dec        <= dec_nxt;
      sec_clr    <= sec_nxt;
      commit     <= 1'b0;

      if (mode_edge) begin
        state  <= next_mode(state);
        commit <= (state == SET_SEC);
      end else if (timeout_fire) begin
        state  <= RUN;
        commit <= 1'b1;
      end

      if (!in_set || activity || timeout_fire) begin
        tcnt <= '0;
      end else if (tick && tcnt != '1) begin
        tcnt <= tcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_sequencer.sv
// Bench for button_sequencer: vector table, directed corner sequences and a random run
// checked every cycle against a tick-counting reference model.
module tb_button_sequencer;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] mode;
  logic       inc, dec, sec_clr, commit;

  always #5 clk = ~clk;

  button_sequencer #(
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .TIMEOUT_TICKS(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .mode(mode), .inc(inc), .dec(dec), .sec_clr(sec_clr), .commit(commit)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: mode number, ticks held since press (-1 = no live hold), idle ticks
  int m_mode;
  bit m_inc, m_dec, m_sec, m_commit;
  bit pm, pu, pd, blocked;
  int up_t, dn_t, idle;

  int c_inc, c_dec, c_sec, c_commit;

  function automatic bit hold_hit(input int t);
    return (t == HOLD) || (t > HOLD && ((t - HOLD) % REP) == 0);
  endfunction

  task automatic model_step(input bit r, input bit m, input bit u, input bit d, input bit t);
    bit medge, uedge, dedge, blk, edit, setm, act, fire;
    if (r) begin
      m_mode = 0; m_inc = 0; m_dec = 0; m_sec = 0; m_commit = 0;
      pm = 1; pu = 1; pd = 1; blocked = 1;
      up_t = -1; dn_t = -1; idle = 0;
      return;
    end
    medge = m && !pm;
    uedge = u && !pu;
    dedge = d && !pd;
    blk   = blocked || (u && d) || medge;
    edit  = (m_mode == 1) || (m_mode == 2);
    setm  = (m_mode != 0);
    m_inc = 0; m_dec = 0; m_sec = 0; m_commit = 0;

    if (edit && !blk && u) begin
      if (uedge) begin m_inc = 1; up_t = 0; end
      else if (up_t >= 0 && t) begin up_t++; if (hold_hit(up_t)) m_inc = 1; end
    end else up_t = -1;

    if (edit && !blk && d) begin
      if (dedge) begin m_dec = 1; dn_t = 0; end
      else if (dn_t >= 0 && t) begin dn_t++; if (hold_hit(dn_t)) m_dec = 1; end
    end else dn_t = -1;

    if (m_mode == 3 && !blk && (uedge || dedge)) m_sec = 1;

    act  = medge || uedge || dedge || m_inc || m_dec;
    fire = 0;
    if (!setm || act) idle = 0;
    else if (t) begin
      idle++;
      if (idle >= TMO) begin fire = 1; idle = 0; end
    end

    if (medge) begin
      m_commit = (m_mode == 3);
      m_mode   = (m_mode + 1) % 4;
    end else if (fire) begin
      m_mode   = 0;
      m_commit = 1;
    end

    blocked = (blocked || (u && d) || medge || fire) && (u || d);
    pm = m; pu = u; pd = d;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    tick = (cyc % 4 == 3);
    @(posedge clk);
    cyc++;
    model_step(rst, btn_mode, btn_up, btn_down, tick);
    #1;
    check("model", int'({mode, inc, dec, sec_clr, commit}),
          int'({2'(m_mode), m_inc, m_dec, m_sec, m_commit}));
    c_inc += int'(inc); c_dec += int'(dec); c_sec += int'(sec_clr); c_commit += int'(commit);
  endtask

  task automatic clr_counts();
    c_inc = 0; c_dec = 0; c_sec = 0; c_commit = 0;
  endtask

  task automatic align();
    while (cyc % 4 == 3) step();
  endtask

  task automatic hold_ticks(input int n);
    int k = 0;
    int lim = 0;
    while (k < n && lim < 1000) begin
      if (cyc % 4 == 3) k++;
      step();
      lim++;
    end
  endtask

  task automatic press_mode();
    align();
    btn_mode = 1; step();
    btn_mode = 0; step();
  endtask

  task automatic goto_mode(input int target);
    int guard = 0;
    while (m_mode != target && guard < 8) begin
      press_mode();
      guard++;
    end
    check("goto_mode", int'(mode), target);
  endtask

  typedef struct {
    bit r, m, u, d;
    int emode;
    bit ei, ed, es, ec;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t v(input bit r, input bit m, input bit u, input bit d,
                             input int em, input bit ei, input bit ed, input bit es,
                             input bit ec);
    vec_t x;
    x.r = r; x.m = m; x.u = u; x.d = d;
    x.emode = em; x.ei = ei; x.ed = ed; x.es = es; x.ec = ec;
    return x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_counts();
    //               r  m  u  d  mode inc dec sec commit
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = v(0, 1, 0, 0, 2, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[6]  = v(0, 1, 0, 0, 3, 0, 0, 0, 0);
    tbl[7]  = v(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[8]  = v(0, 0, 1, 0, 3, 0, 0, 1, 0);
    tbl[9]  = v(0, 0, 1, 0, 3, 0, 0, 0, 0);
    tbl[10] = v(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[11] = v(0, 0, 0, 1, 3, 0, 0, 1, 0);
    tbl[12] = v(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[13] = v(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = v(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = v(0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[18] = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[19] = v(0, 0, 1, 0, 1, 1, 0, 0, 0);
    tbl[20] = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[21] = v(0, 0, 0, 1, 1, 0, 1, 0, 0);
    tbl[22] = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[23] = v(0, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[24] = v(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[25] = v(0, 1, 1, 0, 2, 0, 0, 0, 0);
    tbl[26] = v(0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[27] = v(0, 0, 1, 0, 2, 1, 0, 0, 0);
    tbl[28] = v(0, 0, 0, 0, 2, 0, 0, 0, 0);

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].r; btn_mode = tbl[i].m; btn_up = tbl[i].u; btn_down = tbl[i].d;
      step();
      check($sformatf("vec%0d", i), int'({mode, inc, dec, sec_clr, commit}),
            int'({2'(tbl[i].emode), tbl[i].ei, tbl[i].ed, tbl[i].es, tbl[i].ec}));
    end
    btn_mode = 0; btn_up = 0; btn_down = 0; rst = 0;

    // SET_HR: UP held 12 ticks gives press strobe plus ticks 4,6,8,10,12
    goto_mode(1);
    align(); btn_up = 1; clr_counts(); step();
    check("hr_first_inc", int'(inc), 1);
    hold_ticks(12); step();
    btn_up = 0; step();
    check("hr_inc_count", c_inc, 6);
    check("hr_dec_count", c_dec, 0);

    // SET_MIN: DOWN repeats, UP joins and blocks, stale UP stays silent
    goto_mode(2);
    align(); btn_down = 1; clr_counts(); step();
    hold_ticks(6);
    check("min_dec_count", c_dec, 3);
    align(); btn_up = 1; clr_counts();
    hold_ticks(6);
    check("both_held_strobes", c_inc + c_dec, 0);
    btn_down = 0; clr_counts();
    hold_ticks(6);
    check("stale_up_inc", c_inc, 0);
    btn_up = 0; step();
    align(); btn_up = 1; clr_counts(); step();
    check("repress_inc", int'(inc), 1);
    btn_up = 0; step();

    // SET_SEC: held UP clears seconds once, no inc
    goto_mode(3);
    align(); btn_up = 1; clr_counts(); step();
    hold_ticks(12);
    btn_up = 0; step();
    check("sec_clr_count", c_sec, 1);
    check("sec_inc_count", c_inc, 0);

    // Timeout: 19 idle ticks keep the session, a press restarts, 20 ticks end it
    goto_mode(1);
    align(); btn_up = 1; step(); btn_up = 0; clr_counts();
    hold_ticks(19);
    check("idle19_mode", int'(mode), 1);
    check("idle19_commit", c_commit, 0);
    align(); btn_up = 1; step(); btn_up = 0;
    hold_ticks(19);
    check("restart_mode", int'(mode), 1);
    hold_ticks(1);
    check("timeout_mode", int'(mode), 0);
    check("timeout_commit", int'(commit), 1);

    // Reset mid-repeat with UP held
    goto_mode(1);
    align(); btn_up = 1; step();
    hold_ticks(5);
    rst = 1; step();
    check("rst_outputs", int'({mode, inc, dec, sec_clr, commit}), 0);
    rst = 0; clr_counts();
    hold_ticks(6);
    check("rst_held_strobes", c_inc + c_dec + c_sec + c_commit, 0);
    btn_up = 0; step();
    align(); btn_up = 1; clr_counts(); step();
    check("run_press_inc", int'(inc), 0);
    btn_up = 0; step();
    goto_mode(1);
    align(); btn_up = 1; step();
    check("rearm_press_inc", int'(inc), 1);
    btn_up = 0; step();

    // Random activity against the model
    for (int seg = 0; seg < 40; seg++) begin
      int rate_b, rate_m;
      rate_b = $urandom_range(3, 40);
      rate_m = $urandom_range(10, 200);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, rate_b - 1) == 0) btn_up = ~btn_up;
        if ($urandom_range(0, rate_b - 1) == 0) btn_down = ~btn_down;
        if ($urandom_range(0, rate_m - 1) == 0) btn_mode = ~btn_mode;
        rst = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
